sync_fifo_ptr: RTL

Single-clock FIFO with explicit binary read/write pointers, exported so a downstream binary-to-Gray stage can convert them for pointer comparison or crossing logic. Buffers DATA_WIDTH-bit words in a 2^ADDR_WIDTH-entry array and provides full/empty/count status plus sticky overflow/underflow error flags. Sits directly upstream of the pointer Gray encoder: `wr_ptr` and `rd_ptr` are its binary inputs.

---
 rtl/sync_fifo_ptr.sv | 75 +++++++
 1 files changed

// File: rtl/sync_fifo_ptr.sv
// Single-clock FIFO exporting binary read/write pointers (MSB = wrap bit)
// for a downstream Gray encoder, with sticky overflow/underflow flags.
module sync_fifo_ptr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_accept;
  logic                  rd_accept;

  // Status depends only on registered pointers, so it cannot glitch with wr_en/rd_en.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // NOTE: the storage array has no reset; empty=1 after reset hides stale contents,
  // and leaving it unreset lets synthesis map it onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so full/empty seen by both accept terms are the start-of-cycle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
